// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, NOP encoding and fetch FSM states.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; loads either a fetched instruction or a bubble.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [31:0]        next_pc4,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc4,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      if (bubble) begin
        instr <= NOP;
        pc4   <= 32'h0;
        valid <= 1'b0;
      end else begin
        instr <= next_instr;
        pc4   <= next_pc4;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, imem handshake, one-entry holding buffer and IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pc_write_i,
  input  logic               if_id_write_i,
  input  logic               mem_stall_i,
  input  logic               branch_i,
  input  logic [31:0]        branch_target_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [31:0]        pc_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [31:0]        if_id_pc4_o,
  output logic               if_id_valid_o
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic [31:0]        buf_pc4_q, buf_pc4_d;

  logic               ifid_load, ifid_bubble;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic [31:0]        ifid_pc4_d;

  logic        adv;
  logic [31:0] pc_plus4, req_plus4;

  assign adv       = pc_write_i & if_id_write_i & ~mem_stall_i;
  assign pc_plus4  = pc_q + 32'd4;
  assign req_plus4 = req_addr_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    buf_d        = buf_q;
    buf_pc4_d    = buf_pc4_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b1;
    ifid_instr_d = imem_data_i;
    ifid_pc4_d   = req_plus4;
    imem_req_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d    = FETCH;
        req_addr_d = pc_q;
        ifid_load  = adv;
      end
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          if (!adv) begin
            // Stalled on ack: park the instruction and stop requesting.
            buf_d     = imem_data_i;
            buf_pc4_d = req_plus4;
            state_d   = HOLD;
          end else if (branch_i) begin
            ifid_load  = 1'b1;
            pc_d       = branch_target_i;
            req_addr_d = branch_target_i;
          end else begin
            ifid_load   = 1'b1;
            ifid_bubble = 1'b0;
            pc_d        = pc_plus4;
            req_addr_d  = pc_plus4;
          end
        end else if (adv) begin
          ifid_load = 1'b1;
          if (branch_i) begin
            pc_d    = branch_target_i;
            state_d = DRAIN;
          end
        end
      end
      HOLD: begin
        if (adv) begin
          ifid_load = 1'b1;
          state_d   = FETCH;
          if (branch_i) begin
            pc_d       = branch_target_i;
            req_addr_d = branch_target_i;
          end else begin
            ifid_bubble  = 1'b0;
            ifid_instr_d = buf_q;
            ifid_pc4_d   = buf_pc4_q;
            pc_d         = pc_plus4;
            req_addr_d   = pc_plus4;
          end
        end
      end
      DRAIN: begin
        // Stale request must complete; its data is dropped.
        imem_req_o = 1'b1;
        if (adv) begin
          ifid_load = 1'b1;
          if (branch_i) pc_d = branch_target_i;
        end
        if (imem_ack_i) begin
          req_addr_d = pc_d;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_q      <= NOP;
      buf_pc4_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
      buf_pc4_q  <= buf_pc4_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .next_instr (ifid_instr_d),
    .next_pc4   (ifid_pc4_d),
    .instr      (if_id_instr_o),
    .pc4        (if_id_pc4_o),
    .valid      (if_id_valid_o)
  );

  assign imem_addr_o = req_addr_q;
  assign pc_o        = pc_q;

endmodule
